// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// flappy_pkg
// ----------------------------------------------------------------------------
// Shared types and geometry for the pipe scroller.
//   state_t  : scroller run state (IDLE / RUN / CRASH)
//   GRID_W   : number of grid columns
//   GRID_H   : number of grid rows (pixels per column)
//   grid_idx : flat bit index of pixel (column c, row r) in the packed grid
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_t;

  localparam int GRID_W = 8;
  localparam int GRID_H = 8;

  // Columns are stored contiguously, so pixel (c, r) lives at c*GRID_H + r.
  function automatic logic [5:0] grid_idx(input logic [2:0] c, input logic [2:0] r);
    return 6'(int'(c) * GRID_H + int'(r));
  endfunction

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// bcd_score_counter
// ----------------------------------------------------------------------------
// Two-digit BCD counter that saturates at 99.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset (clears to 00)
//   clr   in   synchronous clear, wins over inc
//   inc   in   add one on this edge (ignored at 99)
//   tens  out  BCD tens digit
//   ones  out  BCD ones digit
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module bcd_score_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule : bcd_score_counter
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
// pipe_scroller
// ----------------------------------------------------------------------------
// Holds an 8x8 pipe grid that scrolls one column left on every scroll step,
// taking the generator's column in at the right edge. Detects a bird/pipe
// collision at a fixed column and keeps a saturating two-digit BCD score.
// Parameters:
//   TICK_DIV  clk cycles per scroll step (>= 2)
//   BIRD_COL  grid column occupied by the bird (0 = leftmost)
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   start       in   begin a run from IDLE / restart from CRASH
//   pattern     in   next pipe column from the generator (bit r = row r)
//   bird_row    in   current bird row 0..7
//   adv         out  one-cycle strobe: generator may advance its column
//   grid        out  grid[c*8+r] = pixel at column c, row r
//   lose        out  high while crashed
//   score_tens  out  BCD tens digit
//   score_ones  out  BCD ones digit
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int BIRD_COL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 pattern,
  input  logic [2:0]                 bird_row,
  output logic                       adv,
  output logic [GRID_W*GRID_H-1:0]   grid,
  output logic                       lose,
  output logic [3:0]                 score_tens,
  output logic [3:0]                 score_ones
);

  localparam int              CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]      BIRD_C  = 3'(BIRD_COL);
  localparam int              GRID_N  = GRID_W * GRID_H;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GRID_N-1:0]  grid_q;
  logic               adv_q;
  logic               lose_q;

  logic [GRID_H-1:0]  bird_col;
  logic               collide;
  logic               step;
  logic               score_inc;
  logic               score_clr;
  logic [GRID_N-1:0]  grid_shift_d;

  // Column currently under the bird, sampled before any shift this cycle.
  assign bird_col = grid_q[BIRD_COL*GRID_H +: GRID_H];

  // Collision is judged on the registered grid, so it lands one cycle late.
  assign collide = (state_q == RUN) && grid_q[grid_idx(BIRD_C, bird_row)];
  assign step    = (state_q == RUN) && (cnt_q == CNT_MAX);

  // A pipe passes when the bird column held pixels as the step scrolls it away.
  // A colliding step is suppressed entirely, including its score.
  assign score_inc = step && !collide && (|bird_col);

  // Leaving IDLE or CRASH on start always begins a fresh run at 00.
  assign score_clr = (state_q != RUN) && start;

  // Column c takes column c+1; the fresh pattern becomes column 7.
  assign grid_shift_d = {pattern, grid_q[GRID_N-1:GRID_H]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grid_q  <= '0;
      adv_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          grid_q <= '0;
          cnt_q  <= '0;
          lose_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (collide) begin
            state_q <= CRASH;
            lose_q  <= 1'b1;
          end else if (step) begin
            cnt_q  <= '0;
            grid_q <= grid_shift_d;
            adv_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CRASH: begin
          lose_q <= 1'b1;
          if (start) begin
            grid_q  <= '0;
            cnt_q   <= '0;
            lose_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          grid_q  <= '0;
          cnt_q   <= '0;
          lose_q  <= 1'b0;
        end
      endcase
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .tens  (score_tens),
    .ones  (score_ones)
  );

  assign adv  = adv_q;
  assign grid = grid_q;
  assign lose = lose_q;

endmodule : pipe_scroller
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// ============================================================================
// tb_pipe_scroller
// ----------------------------------------------------------------------------
// Self-checking bench for pipe_scroller. A column-array / integer-score
// reference model is advanced on every clock edge and compared with the DUT
// outputs on every falling edge, alongside directed scenario checks.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_scroller;

  localparam int TICK_DIV = 4;
  localparam int BIRD_COL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pattern;
  logic [2:0]  bird_row;
  logic        adv;
  logic [63:0] grid;
  logic        lose;
  logic [3:0]  score_tens;
  logic [3:0]  score_ones;

  pipe_scroller #(.TICK_DIV(TICK_DIV), .BIRD_COL(BIRD_COL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .bird_row   (bird_row),
    .adv        (adv),
    .grid       (grid),
    .lose       (lose),
    .score_tens (score_tens),
    .score_ones (score_ones)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=run 2=crash; m_since counts edges since
  // the run (re)started or since the last scroll step.
  int         m_mode;
  int         m_since;
  logic [7:0] m_col [8];
  int         m_score;
  logic       m_adv;
  logic       m_lose;

  int         budget;
  bit         seen19;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_grid();
    logic [63:0] g;
    for (int c = 0; c < 8; c++) g[c*8 +: 8] = m_col[c];
    return g;
  endfunction

  function automatic logic [79:0] m_outs();
    return {6'd0, m_adv, m_lose, 4'(m_score / 10), 4'(m_score % 10), m_grid()};
  endfunction

  function automatic logic [79:0] dut_outs();
    return {6'd0, adv, lose, score_tens, score_ones, grid};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_since = 0;
    for (int c = 0; c < 8; c++) m_col[c] = 8'h00;
    m_score = 0;
    m_adv   = 1'b0;
    m_lose  = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    m_adv = 1'b0;
    case (m_mode)
      0: if (start) begin
        m_mode  = 1;
        m_since = 0;
      end
      1: begin
        if (m_col[BIRD_COL][bird_row]) begin
          m_mode = 2;
          m_lose = 1'b1;
        end else begin
          m_since++;
          if (m_since == TICK_DIV) begin
            m_since = 0;
            if (m_col[BIRD_COL] != 8'h00 && m_score < 99) m_score++;
            for (int c = 0; c < 7; c++) m_col[c] = m_col[c+1];
            m_col[7] = pattern;
            m_adv = 1'b1;
          end
        end
      end
      default: if (start) begin
        for (int c = 0; c < 8; c++) m_col[c] = 8'h00;
        m_score = 0;
        m_since = 0;
        m_lose  = 1'b0;
        m_mode  = 1;
      end
    endcase
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("lockstep", dut_outs(), m_outs());
  endtask

  // Called at a falling edge; reset is raised between edges.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async", dut_outs(), 80'd0);
    clk_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_pattern();
    logic [7:0] p;
    logic [7:0] gap;
    int sel;
    sel = int'($urandom_range(3));
    gap = 8'h07;
    case (sel)
      0:       p = 8'h00;
      1:       p = 8'($urandom);
      default: p = ~(gap << $urandom_range(5));
    endcase
    return p;
  endfunction

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pattern  = 8'h00;
    bird_row = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outs", dut_outs(), 80'd0);
    reset = 1'b0;

    // Basic scrolling with the bird sitting in the gap.
    pattern  = 8'hE7;
    bird_row = 3'd3;
    start    = 1'b1;
    clk_cycle();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      clk_cycle();
      if (k <= 12) check("t1_adv", 80'(adv), 80'((k % 4) == 0));
      if (k == 4)  check("t1_first_col", 80'(grid), 80'({8'hE7, 56'h0}));
    end
    check("t1_full", 80'(grid), {16'h0, {8{8'hE7}}});
    check("t1_lose", 80'(lose), 80'd0);

    // Bird on a pipe row: crash one cycle after column 1 fills, then freeze.
    do_reset();
    pattern  = 8'hE7;
    bird_row = 3'd0;
    start    = 1'b1;
    clk_cycle();
    start = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      clk_cycle();
      if (k == 28) begin
        check("t2_pre_lose", 80'(lose), 80'd0);
        check("t2_pre_grid", 80'(grid), 80'({{7{8'hE7}}, 8'h00}));
      end
      if (k == 29) check("t2_lose", 80'(lose), 80'd1);
    end
    for (int k = 0; k < 20; k++) begin
      clk_cycle();
      check("t2_frozen", dut_outs(), {6'd0, 1'b0, 1'b1, 8'h00, {7{8'hE7}}, 8'h00});
    end

    // Alternating empty / gap columns: score the 19 -> 20 carry.
    do_reset();
    pattern  = 8'h00;
    bird_row = 3'd3;
    start    = 1'b1;
    clk_cycle();
    start  = 1'b0;
    budget = 0;
    seen19 = 1'b0;
    while (m_score < 20 && budget < 2000) begin
      clk_cycle();
      budget++;
      if (adv) pattern = (pattern == 8'h00) ? 8'hE7 : 8'h00;
      if (m_score == 19 && !seen19) begin
        check("t3_19", 80'({score_tens, score_ones}), 80'h19);
        seen19 = 1'b1;
      end
    end
    if (m_score == 20) check("t3_20", 80'({score_tens, score_ones}), 80'h20);
    else               check("t3_timeout", 80'd0, 80'd1);

    // Saturation: well over 99 passes.
    do_reset();
    pattern  = 8'hE7;
    bird_row = 3'd3;
    start    = 1'b1;
    clk_cycle();
    start = 1'b0;
    for (int k = 0; k < 130 * TICK_DIV; k++) clk_cycle();
    check("t4_sat", 80'({score_tens, score_ones}), 80'h99);

    // Crash, then restart from CRASH with a single-cycle start.
    bird_row = 3'd0;
    clk_cycle();
    check("t5_lose", 80'(lose), 80'd1);
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    check("t5_restart", dut_outs(), 80'd0);
    for (int k = 1; k <= 4; k++) begin
      clk_cycle();
      check("t5_adv", 80'(adv), 80'(k == 4));
    end

    // Mid-run asynchronous reset with score 05 and a populated grid.
    bird_row = 3'd3;
    budget   = 0;
    while (m_score < 5 && budget < 400) begin
      clk_cycle();
      budget++;
    end
    if (m_score != 5) check("t6_timeout", 80'd0, 80'd1);
    clk_cycle();
    check("t6_score", 80'({score_tens, score_ones}), 80'h05);
    check("t6_grid_nz", 80'(grid != 64'd0), 80'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async", dut_outs(), 80'd0);
    clk_cycle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) clk_cycle();
    check("t6_idle", dut_outs(), 80'd0);
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      clk_cycle();
      check("t6_adv", 80'(adv), 80'(k == 4));
    end

    // Randomised runs: random columns, bird moves, stray start pulses.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      bird_row = 3'($urandom_range(7));
      pattern  = rand_pattern();
      start    = 1'b1;
      clk_cycle();
      start = 1'b0;
      for (int k = 0; k < 150; k++) begin
        if (adv) pattern = rand_pattern();
        if ($urandom_range(15) == 0) bird_row = 3'($urandom_range(7));
        start = ($urandom_range(9) == 0);
        clk_cycle();
      end
      start = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_scroller
`default_nettype wire

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Downstream consumer of the green-pipe pattern generator.
- Holds an 8x8 grid of pipe pixels. On every scroll tick it samples the generator's 8-bit column, shifts it in at the right edge and scrolls the grid one column left.
- Requests the next column from the generator, detects bird/pipe collision at a fixed column, and keeps a two-digit BCD score.
- Its outputs drive the LED display driver and the lose input of the pattern generator.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per scroll step; must be >= 2. Benches use 4.
- BIRD_COL, 1: grid column (0..7) the bird occupies; 0 is leftmost.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begins a run from IDLE, or restarts from CRASH.
- pattern  in  8  next pipe column from the generator; bit r=1 means pipe pixel at row r.
- bird_row  in  3  current bird row, 0..7.
- adv  out  1  one-cycle strobe telling the upstream generator to advance to its next column.
- grid  out  64  grid[c*8+r] = pixel at column c, row r; column 7 is where new columns enter.
- lose  out  1  high while in CRASH.
- score_tens  out  4  BCD tens digit.
- score_ones  out  4  BCD ones digit.

Behaviour:

Reset (asynchronous):
- state=IDLE, grid=0, tick counter=0.
- adv=0, lose=0, score=00.

States:
- IDLE: grid held at 0, counter held at 0, adv=0. If start=1, go to RUN on the next edge.
- RUN:
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - On the edge where the counter is at TICK_DIV-1 (a "step"):
    - column c <= column c+1 for c=0..6;
    - column 7 <= pattern, sampled on that edge;
    - adv is registered high for exactly the following cycle.
  - The first step occurs TICK_DIV cycles after entering RUN.
  - The generator's output must be stable when adv is low. The value present on the step edge is the one consumed.
- CRASH:
  - grid, score and counter are frozen; adv=0; lose=1.
  - start=1 clears grid, score and counter and goes to RUN on the next edge. lose drops on that same edge.

Collision:
- The condition is grid[BIRD_COL*8+bird_row]==1, evaluated every cycle in RUN on the registered grid.
- When true, the next edge goes to CRASH and lose=1. Latency is 1 cycle from the condition.
- Collision on a step edge: the step is suppressed. No shift, no adv, no score update.
- start is ignored in RUN.

Score:
- On a step edge with no collision, if column BIRD_COL is non-zero before the shift, the score increments by 1 (a pipe passed).
- BCD: ones wraps 9->0 with tens+1.
- Saturates at 99; further passes leave it at 99.

Other rules:
- bird_row is unsigned; every value 0..7 is legal.
- The tick counter width is $clog2(TICK_DIV).
- reset asserted mid-run forces all reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package flappy_pkg:
  - enum {IDLE, RUN, CRASH} for the state;
  - GRID_W=8, GRID_H=8;
  - a helper for the grid index c*GRID_H+r.
- One sub-module, bcd_score_counter:
  - ports: clk, reset, clr, inc, tens, ones;
  - saturating 00..99 counter;
  - clr has priority over inc.

Test Plan:
1. Reset then start=1, TICK_DIV=4, pattern=8'b11100111, bird_row=3:
   - adv pulses on cycles 4, 8, 12 after entry into RUN;
   - after the first step, grid column 7 = 8'hE7 and all others 0;
   - after 8 steps, every column = 8'hE7;
   - lose stays 0 with the bird in the gap.
2. Same setup, bird_row=0:
   - the first step that puts 8'hE7 into column 1 is followed, one cycle later, by lose=1 and state CRASH;
   - grid and score are frozen for 20 cycles with adv=0.
3. Pattern alternating 8'h00 / 8'hE7, bird_row=3:
   - score increments only on steps where column 1 is 8'hE7;
   - after 19 passes, score = tens 1, ones 9; the next pass gives tens 2, ones 0.
4. Force 120 passes (gap pattern, bird in gap): score saturates at tens 9, ones 9.
5. In CRASH, assert start=1 for 1 cycle:
   - the next edge gives grid=0, score=00, lose=0 and state RUN;
   - the first adv comes 4 cycles later.
6. Assert reset asynchronously between clock edges mid-RUN, with a non-zero grid and score=05:
   - grid, adv, lose and score read 0 before the next clk edge;
   - the block stays in IDLE until start is asserted.
